// File: rtl/color_stream_packer_if.sv
// ---------------------------------------------------------------------------
// color_stream_packer_if
// AXI4-Stream video bus carried out of color_stream_packer.
//   tdata  [23:0]  RGB pixel {R,G,B}
//   tvalid         head entry present
//   tready         consumer accepts the head entry
//   tuser          start of frame (x=0, y=0)
//   tlast          end of line (x=H_RES-1)
// master: the packer (source); slave: the consumer (VDMA).
// ---------------------------------------------------------------------------
interface color_stream_packer_if;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/color_stream_packer.sv
// ---------------------------------------------------------------------------
// color_stream_packer
// Packs registered RGB pixels from the colour-LUT stage into an AXI4-Stream
// video stream. A first-word-fall-through FIFO absorbs tready backpressure;
// write-side x/y counters tag each pixel with start-of-frame / end-of-line.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   color[23:0], valid  incoming pixel (no backpressure on this side)
//   almost_full         registered throttle to the upstream pixel engines
//   m_axis (master)     tdata/tvalid/tready/tuser/tlast output stream
//   overflow            sticky: a pixel was dropped on a full FIFO
//   frame_done          1-cycle pulse after the last pixel of a frame leaves
//
// Optional feature macro: COLOR_STREAM_STATS_EN
//   adds frame_count[15:0] (wrapping count of frame_done pulses) and
//   drop_count[15:0] (saturating count of dropped pixels).
// ---------------------------------------------------------------------------
module color_stream_packer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [23:0]            color,
  input  logic                   valid,
  output logic                   almost_full,
  color_stream_packer_if.master  m_axis,
  output logic                   overflow,
  output logic                   frame_done
`ifdef COLOR_STREAM_STATS_EN
  ,
  output logic [15:0]            frame_count,
  output logic [15:0]            drop_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int XW = $clog2(H_RES);
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
  localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_THR = CW'(FIFO_DEPTH - AF_MARGIN);

  // Entry layout: {sof, eol, rgb}
  logic [25:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [YW-1:0] rd_y_q, rd_y_d;
  logic          almost_full_q, almost_full_d;
  logic          overflow_q, overflow_d;
  logic          frame_done_q, frame_done_d;

  logic [25:0]   head;
  logic [25:0]   wr_entry;
  logic          tvalid;
  logic          pop;
  logic          push;
  logic          drop;

  assign head   = mem_q[rd_ptr_q];
  assign tvalid = (count_q != '0);
  assign pop    = tvalid && m_axis.tready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push   = valid && ((count_q < DEPTH) || pop);
  assign drop   = valid && !push;

  assign wr_entry = {(x_q == '0) && (y_q == '0), (x_q == X_LAST), color};

  // Head fields are forced to zero while empty so stale RAM never shows.
  assign m_axis.tvalid = tvalid;
  assign m_axis.tdata  = tvalid ? head[23:0] : '0;
  assign m_axis.tlast  = tvalid && head[24];
  assign m_axis.tuser  = tvalid && head[25];

  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;
  assign frame_done  = frame_done_q;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    x_d           = x_q;
    y_d           = y_q;
    rd_y_d        = rd_y_q;
    overflow_d    = overflow_q || drop;
    frame_done_d  = 1'b0;
    // Registered from current occupancy: one cycle behind, covered by AF_MARGIN.
    almost_full_d = (count_q >= AF_THR);

    // Geometry advances on every valid pixel, stored or dropped.
    if (valid) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Read-side line tracking for frame_done; tuser re-aligns it to line 0.
    if (pop) begin
      if (head[24]) begin
        frame_done_d = (rd_y_q == Y_LAST);
        rd_y_d       = (rd_y_q == Y_LAST) ? '0 : rd_y_q + 1'b1;
      end else if (head[25]) begin
        rd_y_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      rd_y_q        <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      x_q           <= x_d;
      y_q           <= y_d;
      rd_y_q        <= rd_y_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Storage needs no reset: count_q gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= wr_entry;
  end

`ifdef COLOR_STREAM_STATS_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] drop_count_q, drop_count_d;

  always_comb begin
    frame_count_d = frame_count_q + {15'd0, frame_done_q};
    drop_count_d  = drop_count_q;
    if (drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
`endif

endmodule

// File: tb/tb_color_stream_packer.sv
module tb_color_stream_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] color = '0;
  logic        valid = 1'b0;
  logic        almost_full;
  logic        overflow;
  logic        frame_done;
`ifdef COLOR_STREAM_STATS_EN
  logic [15:0] frame_count;
  logic [15:0] drop_count;
`endif
  int checks = 0;
  int failures = 0;

  color_stream_packer_if ifc ();

  color_stream_packer #(.H_RES(4), .V_RES(2), .FIFO_DEPTH(8), .AF_MARGIN(2)) dut (
    .clk(clk),
    .rst(rst),
    .color(color),
    .valid(valid),
    .almost_full(almost_full),
    .m_axis(ifc.master),
    .overflow(overflow),
    .frame_done(frame_done)
`ifdef COLOR_STREAM_STATS_EN
    ,
    .frame_count(frame_count),
    .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; ifc.tready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; color = 24'hDEAD01; ifc.tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({ifc.tvalid, ifc.tuser, ifc.tlast, ifc.tdata, almost_full, overflow, frame_done} !== 30'd0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d tvalid=%b tdata=%h af=%b ovf=%b fd=%b expected all 0",
                 i, ifc.tvalid, ifc.tdata, almost_full, overflow, frame_done);
      end
    end
    rst = 1'b0; valid = 1'b0;
    tick();
    checks++;
    if (ifc.tvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_nothing_stored tvalid=%b expected 0", ifc.tvalid);
    end
  endtask

  task automatic test_streaming();
    int fd_seen = 0;
    ifc.tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      valid = 1'b1; color = 24'(i);
      tick();
      checks++;
      if (ifc.tvalid !== 1'b1 || ifc.tdata !== 24'(i)) begin
        failures++;
        $display("FAIL stream_data i=%0d tvalid=%b tdata=%h expected 1/%h", i, ifc.tvalid, ifc.tdata, 24'(i));
      end
      checks++;
      if (ifc.tuser !== (i == 1) || ifc.tlast !== (i % 4 == 0)) begin
        failures++;
        $display("FAIL stream_flags i=%0d tuser=%b tlast=%b expected %b/%b", i, ifc.tuser, ifc.tlast, (i == 1), (i % 4 == 0));
      end
      if (frame_done === 1'b1) fd_seen++;
    end
    valid = 1'b0;
    tick();
    checks++;
    if (frame_done !== 1'b1 || ifc.tvalid !== 1'b0) begin
      failures++;
      $display("FAIL stream_frame_done fd=%b tvalid=%b expected 1/0", frame_done, ifc.tvalid);
    end
    tick();
    if (frame_done === 1'b1) fd_seen++;
    checks++;
    if (fd_seen !== 0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL stream_fd_single extra_pulses=%0d ovf=%b expected 0/0", fd_seen, overflow);
    end
`ifdef COLOR_STREAM_STATS_EN
    checks++;
    if (frame_count !== 16'd1) begin
      failures++;
      $display("FAIL stream_frame_count got=%0d expected 1", frame_count);
    end
`endif
  endtask

  task automatic test_backpressure();
    do_reset();
    ifc.tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1; color = 24'hAA0000 + 24'(i);
      tick();
      checks++;
      if (ifc.tvalid !== 1'b1 || ifc.tdata !== 24'hAA0000 || almost_full !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold i=%0d tvalid=%b tdata=%h af=%b expected 1/aa0000/0", i, ifc.tvalid, ifc.tdata, almost_full);
      end
    end
    valid = 1'b0;
    tick();
    checks++;
    if (almost_full !== 1'b1 || ifc.tdata !== 24'hAA0000) begin
      failures++;
      $display("FAIL bp_almost_full af=%b tdata=%h expected 1/aa0000", almost_full, ifc.tdata);
    end
    ifc.tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ifc.tvalid !== 1'b1 || ifc.tdata !== 24'hAA0000 + 24'(i) || ifc.tlast !== (i == 3)) begin
        failures++;
        $display("FAIL bp_drain i=%0d tvalid=%b tdata=%h tlast=%b expected 1/%h/%b", i, ifc.tvalid, ifc.tdata, ifc.tlast,
                 24'hAA0000 + 24'(i), (i == 3));
      end
      tick();
    end
    checks++;
    if (ifc.tvalid !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty tvalid=%b ovf=%b expected 0/0", ifc.tvalid, overflow);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    ifc.tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      valid = 1'b1; color = 24'h550000 + 24'(i);
      tick();
      checks++;
      if (overflow !== (i >= 8)) begin
        failures++;
        $display("FAIL ovf_flag i=%0d ovf=%b expected %b", i, overflow, (i >= 8));
      end
    end
    valid = 1'b0; ifc.tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ifc.tvalid !== 1'b1 || ifc.tdata !== 24'h550000 + 24'(i) || ifc.tlast !== (i == 3 || i == 7)
          || ifc.tuser !== (i == 0)) begin
        failures++;
        $display("FAIL ovf_drain i=%0d tvalid=%b tdata=%h tuser=%b tlast=%b expected 1/%h/%b/%b", i, ifc.tvalid,
                 ifc.tdata, ifc.tuser, ifc.tlast, 24'h550000 + 24'(i), (i == 0), (i == 3 || i == 7));
      end
      tick();
    end
    checks++;
    if (frame_done !== 1'b1 || ifc.tvalid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_frame_done fd=%b tvalid=%b expected 1/0", frame_done, ifc.tvalid);
    end
    // Dropped pixels 8,9 still advanced x, so pixel 10 sits at x=2 and 16 starts frame 3.
    for (int i = 10; i <= 16; i++) begin
      valid = 1'b1; color = 24'h550000 + 24'(i);
      tick();
      checks++;
      if (ifc.tdata !== 24'h550000 + 24'(i) || ifc.tuser !== (i == 16) || ifc.tlast !== (i == 11 || i == 15)) begin
        failures++;
        $display("FAIL ovf_geometry i=%0d tdata=%h tuser=%b tlast=%b expected %h/%b/%b", i, ifc.tdata, ifc.tuser,
                 ifc.tlast, 24'h550000 + 24'(i), (i == 16), (i == 11 || i == 15));
      end
    end
    valid = 1'b0;
    tick();
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky ovf=%b expected 1", overflow);
    end
`ifdef COLOR_STREAM_STATS_EN
    checks++;
    if (drop_count !== 16'd2) begin
      failures++;
      $display("FAIL ovf_drop_count got=%0d expected 2", drop_count);
    end
`endif
  endtask

  task automatic test_full_push_pop();
    do_reset();
    ifc.tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1; color = 24'h330000 + 24'(i);
      tick();
    end
    ifc.tready = 1'b1; valid = 1'b1; color = 24'h330008;
    tick();
    valid = 1'b0;
    checks++;
    if (overflow !== 1'b0 || ifc.tvalid !== 1'b1 || ifc.tdata !== 24'h330001) begin
      failures++;
      $display("FAIL full_pp_accept ovf=%b tvalid=%b tdata=%h expected 0/1/330001", overflow, ifc.tvalid, ifc.tdata);
    end
    // Exactly 8 entries remain: 330001..330008.
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (ifc.tvalid !== 1'b1 || ifc.tdata !== 24'h330000 + 24'(i)) begin
        failures++;
        $display("FAIL full_pp_drain i=%0d tvalid=%b tdata=%h expected 1/%h", i, ifc.tvalid, ifc.tdata, 24'h330000 + 24'(i));
      end
      tick();
    end
    checks++;
    if (ifc.tvalid !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_pp_count tvalid=%b ovf=%b expected 0/0", ifc.tvalid, overflow);
    end
  endtask

  task automatic test_mid_frame_reset();
    do_reset();
    ifc.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1; color = 24'h660000 + 24'(i);
      tick();
    end
    valid = 1'b0;
    checks++;
    if (ifc.tvalid !== 1'b1 || ifc.tdata !== 24'h660000) begin
      failures++;
      $display("FAIL mid_queued tvalid=%b tdata=%h expected 1/660000", ifc.tvalid, ifc.tdata);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ifc.tvalid !== 1'b0 || ifc.tdata !== 24'h0) begin
      failures++;
      $display("FAIL mid_reset_flush tvalid=%b tdata=%h expected 0/0", ifc.tvalid, ifc.tdata);
    end
    ifc.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; color = 24'h770000 + 24'(i);
      tick();
      checks++;
      if (ifc.tdata !== 24'h770000 + 24'(i) || ifc.tuser !== (i == 0) || ifc.tlast !== (i == 3)) begin
        failures++;
        $display("FAIL mid_restart i=%0d tdata=%h tuser=%b tlast=%b expected %h/%b/%b", i, ifc.tdata, ifc.tuser,
                 ifc.tlast, 24'h770000 + 24'(i), (i == 0), (i == 3));
      end
    end
    valid = 1'b0;
    tick();
  endtask

  initial begin
    ifc.tready = 1'b0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_overflow();
    test_full_push_pop();
    test_mid_frame_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
